// File: rtl/sram_1rw1r_param_pkg.sv
// sram_1rw1r_param_pkg: shared types for the parametrised 1RW+1R SRAM model
package sram_1rw1r_param_pkg;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;
  localparam int LANE_W = 8;
endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: 1- or 2-cycle read pipeline with a holding output and an aligned flag pulse
module sram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  flag,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  flag_out
);
  logic                  v;
  logic [DATA_WIDTH-1:0] d;
  logic                  f;
  if (READ_LAT == 2) begin : g_stage
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v <= 1'b0;
        d <= '0;
        f <= 1'b0;
      end else begin
        v <= vld;
        d <= data;
        f <= flag;
      end
  end else begin : g_direct
    assign v = vld;
    assign d = data;
    assign f = flag;
  end
  // flag is a single-cycle pulse, while dout holds between reads
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout     <= '0;
      flag_out <= 1'b0;
    end else begin
      flag_out <= v & f;
      if (v) dout <= d;
    end
endmodule

// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: parametrised 1RW+1R SRAM model with byte masks, read latency,
// read-during-write collision handling and a post-reset clear sequencer
module sram_1rw1r_param
  import sram_1rw1r_param_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter int NUM_WMASKS     = DATA_WIDTH / 8,
  parameter int READ_LAT       = 1,
  parameter int RDW_NEW        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  init_busy,
  output logic                  collision
);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  clr_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  in0, in1, we0, rd0, rd1, hit, unused_flag0;
  logic [DATA_WIDTH-1:0] old0, old1, wr_word;
  assign init_busy = state == CLEAR;
  always_comb begin
    state_nxt = (state == CLEAR && cnt == LAST) ? IDLE : state;
    in0       = {1'b0, addr0} < DEPTH_W;
    in1       = {1'b0, addr1} < DEPTH_W;
    we0       = !init_busy && !csb0 && !web0 && in0;
    rd0       = !init_busy && !csb0 && web0;
    rd1       = !init_busy && !csb1;
    hit       = we0 && in1 && addr0 == addr1;
    old0      = in0 ? mem[addr0] : '0;
    old1      = in1 ? mem[addr1] : '0;
    wr_word   = old0;
    for (int i = 0; i < NUM_WMASKS; i++)
      wr_word[LANE_W*i +: LANE_W] = wmask0[i] ? din0[LANE_W*i +: LANE_W] : old0[LANE_W*i +: LANE_W];
  end
  always_ff @(posedge clk0 or posedge rst0)
    if (rst0) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= init_busy ? cnt + 1'b1 : cnt;
    end
  // the array itself has no reset; it is zeroed by the sequencer instead
  always_ff @(posedge clk0)
    if (!rst0) begin
      if (init_busy) mem[cnt] <= '0;
      else if (we0) mem[addr0] <= wr_word;
    end
  sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LAT(READ_LAT)) u_pipe0 (
    .clk(clk0), .rst(rst0), .vld(rd0), .data(old0), .flag(1'b0),
    .dout(dout0), .flag_out(unused_flag0)
  );
  sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LAT(READ_LAT)) u_pipe1 (
    .clk(clk0), .rst(rst0), .vld(rd1),
    .data((hit && RDW_NEW != 0) ? wr_word : old1), .flag(rd1 && hit),
    .dout(dout1), .flag_out(collision)
  );
endmodule

// File: tb/tb_sram_1rw1r_param.sv
// tb_sram_1rw1r_param: two configurations driven by shared random/directed stimulus,
// each checked by its own behavioural model and scoreboard
module tb_sram_1rw1r_param;
  typedef struct {int due; logic [31:0] d; logic c;} ent_t;
  logic        clk = 0, rst = 1, csb0 = 1, web0 = 1, csb1 = 1;
  logic [3:0]  wmask0 = 0;
  logic [7:0]  addr0 = 0, addr1 = 0;
  logic [31:0] din0 = 0;
  logic [31:0] dout0 [2];
  logic [31:0] dout1 [2];
  logic        coll [2];
  logic        busy_o [2];
  int          mtot = 0, mpass = 0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int DEP = k == 0 ? 256 : 200;
    localparam int RL  = k == 0 ? 1 : 2;
    localparam int RN  = k == 0 ? 0 : 1;
    sram_1rw1r_param #(.DEPTH(DEP), .READ_LAT(RL), .RDW_NEW(RN)) dut (
      .clk0(clk), .rst0(rst), .csb0(csb0), .web0(web0), .wmask0(wmask0),
      .addr0(addr0), .din0(din0), .dout0(dout0[k]), .csb1(csb1), .addr1(addr1),
      .dout1(dout1[k]), .init_busy(busy_o[k]), .collision(coll[k])
    );
    logic [31:0] m [256];
    int          busy = 0, e = 0, tot = 0, pass = 0;
    bit          on = 0;
    ent_t        q0 [$];
    ent_t        q1 [$];
    logic [31:0] h0 = 0, h1 = 0;
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tot++;
      if (act === exp) pass++;
      else $display("FAIL cfg%0d %s @edge %0d: got %h want %h", k, nm, e, act, exp);
    endtask
    always @(posedge clk) begin : model
      logic [31:0] r0, r1, nw;
      logic        hit;
      e++;
      if (rst) begin
        busy = DEP;
        q0.delete();
        q1.delete();
        on = 1;
      end else if (on && busy > 0) begin
        m[DEP-busy] = 0;
        busy--;
      end else if (on) begin
        r0 = int'(addr0) < DEP ? m[addr0] : 0;
        r1 = int'(addr1) < DEP ? m[addr1] : 0;
        nw = r0;
        for (int i = 0; i < 4; i++) if (wmask0[i]) nw[8*i +: 8] = din0[8*i +: 8];
        hit = !csb0 && !web0 && int'(addr0) < DEP && !csb1 && addr0 == addr1;
        if (!csb1) q1.push_back('{e + RL - 1, (hit && RN == 1) ? nw : r1, hit});
        if (!csb0 && web0) q0.push_back('{e + RL - 1, r0, 1'b0});
        if (!csb0 && !web0 && int'(addr0) < DEP) m[addr0] = nw;
      end
    end
    always @(negedge clk) begin : mon
      logic c;
      c = 0;
      if (on && rst) begin
        h0 = 0;
        h1 = 0;
        chk("rst_dout0", dout0[k], 0);
        chk("rst_dout1", dout1[k], 0);
        chk("rst_collision", coll[k], 0);
        chk("rst_init_busy", busy_o[k], 1);
      end else if (on) begin
        while (q0.size() > 0 && q0[0].due <= e) begin
          h0 = q0[0].d;
          void'(q0.pop_front());
        end
        while (q1.size() > 0 && q1[0].due <= e) begin
          h1 = q1[0].d;
          c  = q1[0].c;
          void'(q1.pop_front());
        end
        chk("dout0", dout0[k], h0);
        chk("dout1", dout1[k], h1);
        chk("collision", coll[k], c);
        chk("init_busy", busy_o[k], busy > 0);
      end
    end
  end

  task automatic dchk(string nm, logic [31:0] act, logic [31:0] exp);
    mtot++;
    if (act === exp) mpass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  task automatic cyc(input logic c0, input logic w0, input logic [3:0] mk, input logic [7:0] a0,
                     input logic [31:0] d, input logic c1, input logic [7:0] a1);
    @(negedge clk);
    #1;
    csb0 = c0; web0 = w0; wmask0 = mk; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1, 1, 0, 0, 0, 1, 0);
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] mk);
    cyc(0, 0, mk, a, d, 1, 0);
  endtask
  task automatic pulse_rst();
    @(negedge clk);
    #1 rst = 1; csb0 = 1; csb1 = 1;
    @(negedge clk);
    #1 rst = 0;
  endtask
  task automatic wait_ready();
    int i = 0;
    while ((busy_o[0] || busy_o[1]) && i < 600) begin
      idle(1);
      i++;
    end
    dchk("init_done", {31'b0, busy_o[0] | busy_o[1]}, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst = 0;
    wait_ready();
    wr(5, 32'hDEADBEEF, 4'hF);
    cyc(0, 1, 0, 5, 0, 1, 0);
    idle(2);
    dchk("poke5", dout0[0], 32'hDEADBEEF);
    pulse_rst();
    wait_ready();
    cyc(0, 1, 0, 5, 0, 0, 5);
    idle(2);
    dchk("cleared5_p0", dout0[1], 0);
    dchk("cleared5_p1", dout1[0], 0);
    wr(8'h10, 32'h11223344, 4'hF);
    wr(8'h10, 32'hAABBCCDD, 4'h5);
    cyc(0, 1, 0, 8'h10, 0, 1, 0);
    idle(1);
    dchk("mask_lat1", dout0[0], 32'h11BB33DD);
    idle(1);
    dchk("mask_lat2", dout0[1], 32'h11BB33DD);
    cyc(0, 0, 4'hF, 8'h20, 0, 0, 8'h10);
    cyc(0, 0, 4'h3, 8'h20, 32'hFFFFFFFF, 0, 8'h20);
    idle(1);
    dchk("coll_old_data", dout1[0], 0);
    dchk("coll_flag_lat1", coll[0], 1);
    idle(1);
    dchk("coll_new_data", dout1[1], 32'h0000FFFF);
    dchk("coll_flag_lat2", coll[1], 1);
    dchk("coll_pulse_end", coll[0], 0);
    wr(1, 1, 4'hF);
    wr(2, 2, 4'hF);
    wr(3, 3, 4'hF);
    cyc(1, 1, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 2);
    dchk("stream1", dout1[0], 1);
    cyc(1, 1, 0, 0, 0, 0, 3);
    dchk("stream2", dout1[0], 2);
    dchk("stream1_lat2", dout1[1], 1);
    idle(1);
    dchk("stream3", dout1[0], 3);
    idle(3);
    dchk("hold_lat1", dout1[0], 3);
    dchk("hold_lat2", dout1[1], 3);
    pulse_rst();
    idle(100);
    pulse_rst();
    wr(8'h40, 32'h12345678, 4'hF);
    wait_ready();
    cyc(0, 1, 0, 8'h40, 0, 1, 0);
    idle(2);
    dchk("busy_write_dropped1", dout0[0], 0);
    dchk("busy_write_dropped2", dout0[1], 0);
    wr(50, 32'h50505050, 4'hF);
    wr(250, 32'hCAFEF00D, 4'hF);
    cyc(0, 1, 0, 250, 0, 0, 50);
    idle(2);
    dchk("oor_read", dout0[1], 0);
    dchk("oor_alias_untouched", dout1[1], 32'h50505050);
    dchk("in_range_250", dout0[0], 32'hCAFEF00D);
    repeat (800) begin
      logic [7:0] a0, a1;
      a0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          a0, $urandom, 1'($urandom_range(0, 1)), a1);
    end
    idle(4);
    $display("%0d/%0d checks passed", mpass + g[0].pass + g[1].pass, mtot + g[0].tot + g[1].tot);
    $finish;
  end
endmodule
